// File: rtl/hex_disp_pkg.sv
// Shared widths, scan-state encoding, display payload and blanking helper for the hex display scanner.
package hex_disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam int unsigned VALUE_W    = NUM_DIGITS * DIGIT_W;

    typedef enum logic {
        DEAD  = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] dp;
        logic [VALUE_W-1:0]    value;
    } disp_word_t;

    // A digit above 0 goes dark when it and every digit to its left are zero and its point is off.
    function automatic logic digit_blanked(input disp_word_t w, input logic [IDX_W-1:0] idx);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (d >= 32'(idx)) begin
                upper_zero = upper_zero & (w.value[d*DIGIT_W +: DIGIT_W] == '0);
            end
        end
        return (idx != '0) && upper_zero && !w.dp[idx];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the terminal count in the same cycle.
module tick_gen #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned CNT_W = $clog2(DIV)
) (
    input  logic             Clk,
    input  logic             nRst,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    // tc is registered alongside count so it is high exactly while count == DIV-1.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (tc) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count + CNT_W'(1);
            tc    <= (count == CNT_W'(DIV - 2));
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed four-digit hex scanner: anode timing, dead-time, leading-zero blanking and frame-synchronous value update.
module hex_display_scanner
    import hex_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  nRst,
    input  logic [VALUE_W-1:0]    Value,
    input  logic [NUM_DIGITS-1:0] DPIn,
    input  logic                  Load,
    input  logic                  LZB,
    output logic [DIGIT_W-1:0]    Hex,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] An,
    output logic                  FrameDone
);

    localparam int unsigned      CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  tc;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    scan_state_t           state;
    scan_state_t           state_nxt;
    disp_word_t            active_q;
    disp_word_t            active_nxt;
    disp_word_t            pend_q;
    logic                  pend_vld;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [DIGIT_W-1:0]    hex_nxt;
    logic                  dp_nxt;
    logic                  fd_nxt;

    tick_gen #(
        .DIV   (REFRESH_DIV),
        .CNT_W (CNT_W)
    ) u_tick (
        .Clk   (Clk),
        .nRst  (nRst),
        .count (cnt),
        .tc    (tc)
    );

    // Scan state and registered display outputs; async reset blanks the anodes immediately.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state     <= DEAD;
            idx       <= '0;
            An        <= '1;
            Hex       <= '0;
            DP        <= 1'b0;
            FrameDone <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            An        <= an_nxt;
            Hex       <= hex_nxt;
            DP        <= dp_nxt;
            FrameDone <= fd_nxt;
        end
    end

    // Pending capture wins over the frame-end clear so a Load in the FrameDone cycle is kept.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            active_q <= '0;
            pend_q   <= '0;
            pend_vld <= 1'b0;
        end else begin
            active_q <= active_nxt;
            if (Load) begin
                pend_q   <= '{dp: DPIn, value: Value};
                pend_vld <= 1'b1;
            end else if (FrameDone) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Outputs are computed from the next-cycle scan position so they line up with the prescaler count.
    always_comb begin
        cnt_nxt    = tc ? '0 : cnt + CNT_W'(1);
        idx_nxt    = tc ? idx + IDX_W'(1) : idx;
        active_nxt = (FrameDone && pend_vld) ? pend_q : active_q;
        state_nxt  = state;
        an_nxt     = '1;

        case (state)
            DEAD:  if (DEAD_CYCLES == 0 || cnt_nxt == CNT_W'(DEAD_CYCLES)) state_nxt = DRIVE;
            DRIVE: if (tc && DEAD_CYCLES != 0) state_nxt = DEAD;
        endcase

        if (state_nxt == DRIVE && !(LZB && digit_blanked(active_nxt, idx_nxt))) begin
            an_nxt = ~(NUM_DIGITS'(1) << idx_nxt);
        end

        hex_nxt = active_nxt.value[idx_nxt*DIGIT_W +: DIGIT_W];
        dp_nxt  = active_nxt.dp[idx_nxt];
        fd_nxt  = (cnt_nxt == CNT_W'(REFRESH_DIV - 1)) && (idx_nxt == LAST_IDX);
    end

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter DEAD_CYCLES, default 2, cycles at slot start with all anodes off; SHALL be < REFRESH_DIV.
REQ-003 Clk  in  1  sole clock; all state on rising edge.
REQ-004 nRst  in  1  reset, asynchronous assert, active-low.
REQ-005 Value  in  16  four hex digits; [3:0] = digit 0 (rightmost).
REQ-006 DPIn  in  4  decimal-point request per digit; 1 = lit.
REQ-007 Load  in  1  one-cycle strobe capturing Value/DPIn.
REQ-008 LZB  in  1  leading-zero blanking enable.
REQ-009 Hex  out  4  nibble for the downstream hex-to-7-segment decoder.
REQ-010 DP  out  1  decimal point for the downstream decoder; 1 = lit.
REQ-011 An  out  4  digit anode enables, active-low; An[i] drives digit i.
REQ-012 FrameDone  out  1  one-cycle pulse at the end of digit-3 slot.

Function
REQ-013 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; terminal count marks slot end.
REQ-014 Digit index SHALL advance 0->1->2->3->0 on each slot end.
REQ-015 FSM states: DEAD (An=4'b1111) for prescaler 0..DEAD_CYCLES-1, DRIVE for remaining counts; DEAD->DRIVE at count DEAD_CYCLES, DRIVE->DEAD at slot end.
REQ-016 In DRIVE, An SHALL equal ~(4'b0001 << idx) unless the digit is blanked (REQ-019).
REQ-017 Hex and DP SHALL be registered and reflect active digit idx from the first DEAD cycle of its slot, stable for the whole slot.
REQ-018 Load SHALL copy Value/DPIn into pending registers and set a pending flag; later Load before transfer overwrites (latest wins).
REQ-019 With LZB=1, digit i (i>0) SHALL be blanked when it and all higher digits of the active value are 0 and its DP bit is 0; digit 0 never blanked.
REQ-020 Active registers SHALL update from pending only in the FrameDone cycle when pending flag is set; flag clears in that cycle.
REQ-021 Load coincident with FrameDone SHALL be captured into pending and applied at the following frame end.
REQ-022 LZB SHALL be sampled each cycle (no latching); change takes effect on the next DRIVE decision.
REQ-023 FrameDone SHALL assert in the cycle prescaler=REFRESH_DIV-1 and idx=3.
REQ-024 Display latency from Load to first visible new digit 0: at most one full frame plus one slot.

Reset
REQ-025 On nRst low: prescaler=0, idx=0, state=DEAD, An=4'b1111, Hex=4'h0, DP=0, FrameDone=0, active and pending registers=0, pending flag=0.
REQ-026 Reset mid-slot SHALL blank all anodes immediately (asynchronously) and restart scanning at digit 0 after release.
REQ-027 Release SHALL be synchronised in the instantiating top; block assumes deassertion clean to Clk.

Structure
REQ-028 Shared package hex_disp_pkg SHALL hold NUM_DIGITS=4, DIGIT_W=4, and the scan-state enum (DEAD, DRIVE).
REQ-029 Prescaler SHALL be a separate sub-module tick_gen (parameter DIV; outputs count and terminal-count pulse).
REQ-030 Block SHALL NOT instantiate the segment decoder; the top connects Hex/DP to it.
REQ-031 Target size 120-400 lines RTL; no latches, no combinational outputs.

Verification (REFRESH_DIV=8, DEAD_CYCLES=2)
REQ-032 Reset: hold nRst=0 10 cycles, release -> An=4'b1111 cycles 0-1, An=4'b1110 cycles 2-7, Hex=0.
REQ-033 Load Value=16'h12AF, DPIn=4'b0100 -> after next FrameDone, slots show Hex F,A,2,1 with DP=1 only in digit-2 slot; An 1110,1101,1011,0111 in DRIVE.
REQ-034 LZB=1, Value=16'h0030 -> digits 2,3 blanked (An=4'b1111 whole slot), digits 0,1 driven; with DPIn=4'b1000, digit 3 driven, digit 2 blanked.
REQ-035 Load 16'h1111 then 16'h2222 in same frame -> only 2222 ever displayed; Load asserted in FrameDone cycle -> value appears one frame later.
REQ-036 nRst pulsed low mid digit-2 DRIVE -> An=4'b1111 within same cycle; restart at digit 0, active value=0.
REQ-037 Count FrameDone pulses over 320 cycles -> exactly 10, each one cycle wide.
